mod_mul_const_seq: RTL
======================

# mod_mul_const_seq

Sequential, parametrised modular constant multiplier for the residue-arithmetic datapath. It computes (x·K) mod M for any W-bit input using a bit-serial MSB-first double-and-add loop. It also has an optional multiply-accumulate mode that keeps a running residue. It replaces the per-constant, per-modulus combinational lookup blocks wherever area matters more than latency. It is stream-connected through valid/ready on both sides.

## Interface
- M, 53: modulus; must be ≥ 2.
- K, 59: multiplier constant, 0 ≤ K < 2^32; reduced internally to KR = K mod M at elaboration.
- W, $clog2(M): input/output data width; must satisfy 2^W ≥ M.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand; high only in IDLE.
- in_data  in  W  operand x, any value 0..2^W−1; values ≥ M are legal.
- in_acc  in  1  sampled with the operand; selects MAC mode.
- in_clr  in  1  sampled with the operand; clears the accumulator before this operation.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  W  result residue, always < M.

## Operation
- State machine with states IDLE, BUSY, ACCADD and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch x, in_acc and in_clr. If in_clr=1, set acc_reg←0 on the same edge.
  - Set r←0 and bit index i←W−1, then go to BUSY.
- BUSY, one step per cycle: r ← (2r + x[i]·KR) mod M.
  - The sum is < 3M, so reduce with at most two conditional subtractions of M.
  - Internal width is W+2 bits.
  - After the step with i=0, go to ACCADD if in_acc=1, otherwise go to DONE.
- ACCADD, one cycle: r ← (r + acc_reg) mod M with one conditional subtraction; acc_reg ← the same value. Then go to DONE.
- DONE: out_valid=1 and out_data=r. On out_valid&out_ready, go to IDLE.
- Non-MAC operations never modify acc_reg.
- in_clr=1 together with in_acc=1: clear first, then accumulate, so the result is (x·K) mod M.
- in_clr=1 with in_acc=0: clears acc_reg and returns the plain product.
- There is no overlap between operations: a new operand is never accepted while BUSY, ACCADD or DONE.
- Degenerate cases:
  - KR=0 (K a multiple of M): every result is 0.
  - x=0: result 0 in plain mode, acc_reg in MAC mode.

## Timing
- Reset, asynchronous: state=IDLE, in_ready=1, out_valid=0, out_data=0, r=0, acc_reg=0.
- Reset mid-operation aborts the operation. No result is produced and acc_reg=0.
- Accept edge E0. BUSY steps occur on edges E1..EW.
- Plain mode: out_valid is high in the cycle after EW, a latency of W cycles.
- MAC mode: ACCADD occurs on edge EW+1, so out_valid is high after EW+1, a latency of W+1 cycles.
- out_data is stable while out_valid=1 and out_ready=0, indefinitely.
- The output handshake edge returns the block to IDLE, and in_ready=1 in the following cycle.
- Throughput:
  - Plain mode: one result per W+2 cycles when out_ready is held high.
  - MAC mode: one result per W+3 cycles.
- in_data, in_acc and in_clr are ignored whenever in_ready=0.

## Test plan
- Plain mode, defaults (M=53, K=59, KR=6, W=6):
  - x=10 → out_data=7, with out_valid first high 6 cycles after accept.
  - x=52 → 47.
  - x=0 → 0.
- Out-of-range input, defaults: x=63 → 7; x=53 → 0.
- MAC sequence, defaults:
  - in_clr=1,in_acc=1,x=10 → 7, latency 7.
  - Then in_acc=1,x=52 → 1.
  - Then plain x=10 → 7, after which a MAC with x=0 → 1 (accumulator unchanged by the plain operation).
- Backpressure: hold out_ready=0 for 20 cycles in DONE → out_data constant, in_ready=0, and in_valid pulses are ignored. Release → handshake, then IDLE.
- Reset mid-BUSY: assert rst on the cycle after E3 → outputs take reset values immediately. A following MAC with x=10 and no clear returns 7.
- Exhaustive sweep for each parameter set (M=53,K=59), (M=7,K=14, KR=0), (M=97,K=5,W=7) and (M=2,K=3,W=1):
  - All x in 0..2^W−1 in plain mode → matches (x·K) mod M.
  - Random MAC chains are compared against a reference model.

Source files
------------

// File: rtl/mod_mul_const_seq.sv
// ---------------------------------------------------------------------------
// mod_mul_const_seq
//   Bit-serial modular constant multiplier: result = (x * K) mod M, computed
//   MSB-first by double-and-add, one operand bit per cycle. An optional
//   multiply-accumulate mode adds the product into a running residue
//   (acc_reg) that survives across operations.
//
// Parameters
//   M  modulus (>= 2)
//   K  multiplier constant, reduced at elaboration to KR = K mod M
//   W  data width, 2^W >= M
//
// Ports
//   clk, rst    clock; asynchronous active-high reset
//   in_valid    operand offered
//   in_ready    operand accepted this cycle when in_valid is also high (IDLE only)
//   in_data     operand x, any W-bit value (values >= M are legal)
//   in_acc      sampled with the operand: MAC mode
//   in_clr      sampled with the operand: clear acc_reg before this operation
//   out_valid   result held (DONE)
//   out_ready   downstream takes the result
//   out_data    result residue, always < M
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the sender keeps data stable while valid is high and ready low.
// ---------------------------------------------------------------------------
module mod_mul_const_seq #(
    parameter longint unsigned M = 53,
    parameter longint unsigned K = 59,
    parameter int              W = $clog2(M)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_acc,
    input  logic         in_clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Two guard bits: the doubled residue plus KR stays below 3M < 2^(W+2).
    localparam int XW    = W + 2;
    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

    localparam logic [XW-1:0]    M_X     = XW'(M);
    localparam logic [XW-1:0]    KR_X    = XW'(K % M);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        ACCADD = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [W-1:0]     x_reg;
    logic             mac_mode;
    logic [W-1:0]     r;
    logic [W-1:0]     acc_reg;
    logic [IDX_W-1:0] bit_idx;

    logic [XW-1:0] dbl_sum;
    logic [XW-1:0] dbl_s1;
    logic [W-1:0]  dbl_red;
    logic [XW-1:0] acc_sum;
    logic [W-1:0]  acc_red;

    // Double-and-add step and the accumulate step, both fully reduced.
    always_comb begin
        dbl_sum = {1'b0, r, 1'b0} + (x_reg[bit_idx] ? KR_X : '0);
        dbl_s1  = (dbl_sum >= M_X) ? (dbl_sum - M_X) : dbl_sum;
        dbl_red = W'((dbl_s1 >= M_X) ? (dbl_s1 - M_X) : dbl_s1);
        acc_sum = {2'b00, r} + {2'b00, acc_reg};
        acc_red = W'((acc_sum >= M_X) ? (acc_sum - M_X) : acc_sum);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (bit_idx == '0) state_nxt = mac_mode ? ACCADD : DONE;
            end
            ACCADD: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg    <= '0;
            mac_mode <= 1'b0;
            r        <= '0;
            acc_reg  <= '0;
            bit_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg    <= in_data;
                        mac_mode <= in_acc;
                        r        <= '0;
                        bit_idx  <= IDX_TOP;
                        // Clearing here lets a clear+accumulate op add into zero.
                        if (in_clr) acc_reg <= '0;
                    end
                end
                BUSY: begin
                    r       <= dbl_red;
                    bit_idx <= bit_idx - IDX_W'(1);
                end
                ACCADD: begin
                    r       <= acc_red;
                    acc_reg <= acc_red;
                end
                default: ;
            endcase
        end
    end

    // r only changes in BUSY/ACCADD, so it is stable for the whole DONE phase.
    assign out_data = r;

endmodule
